// File: rtl/bicubic_window_feeder_if.sv
// ---------------------------------------------------------------------------
// bicubic_window_feeder_if
//   Bundles every handshake/bus signal of the bicubic window feeder.
//
//   Upstream columns   : col_valid, col_ready, col_data[4*CW], col_sol
//   Upsampler request  : bf_req_valid, bcci_req_ready, p1..p16
//   Upsampler response : bcci_rsp_valid, bf_rsp_ready, bcci_rsp_data1..8
//   Downstream output  : out_valid, out_ready, out_data[8*CW], out_phase
//
//   Modport slave  : the feeder's view (used by bicubic_window_feeder).
//   Modport master : the surrounding environment's view.
// ---------------------------------------------------------------------------
interface bicubic_window_feeder_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                         col_valid;
    logic                         col_ready;
    logic [4*CHANNEL_WIDTH-1:0]   col_data;
    logic                         col_sol;

    logic                         bf_req_valid;
    logic                         bcci_req_ready;
    logic [CHANNEL_WIDTH-1:0]     p1, p2, p3, p4, p5, p6, p7, p8;
    logic [CHANNEL_WIDTH-1:0]     p9, p10, p11, p12, p13, p14, p15, p16;

    logic                         bcci_rsp_valid;
    logic                         bf_rsp_ready;
    logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4;
    logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data5, bcci_rsp_data6, bcci_rsp_data7, bcci_rsp_data8;

    logic                         out_valid;
    logic                         out_ready;
    logic [8*CHANNEL_WIDTH-1:0]   out_data;
    logic                         out_phase;

    modport slave (
        input  col_valid, col_data, col_sol,
        output col_ready,
        output bf_req_valid,
        input  bcci_req_ready,
        output p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16,
        input  bcci_rsp_valid,
        output bf_rsp_ready,
        input  bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
        input  bcci_rsp_data5, bcci_rsp_data6, bcci_rsp_data7, bcci_rsp_data8,
        output out_valid, out_data, out_phase,
        input  out_ready
    );

    modport master (
        output col_valid, col_data, col_sol,
        input  col_ready,
        input  bf_req_valid,
        output bcci_req_ready,
        input  p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16,
        output bcci_rsp_valid,
        input  bf_rsp_ready,
        output bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
        output bcci_rsp_data5, bcci_rsp_data6, bcci_rsp_data7, bcci_rsp_data8,
        input  out_valid, out_data, out_phase,
        output out_ready
    );
endinterface

// File: rtl/bicubic_window_feeder.sv
// ---------------------------------------------------------------------------
// bicubic_window_feeder
//   Collects 4-pixel columns into a 4x4 window, presents the window to a
//   bicubic upsampler for two response phases, and buffers the upsampled
//   8-pixel responses in a 2-entry FIFO towards the downstream consumer.
//
//   Ports:
//     clk     : single clock, rising edge
//     rst_n   : asynchronous active-low reset
//     io_feed : bicubic_window_feeder_if.slave (column input, window request,
//               upsampler response, downstream output)
//
//   Optional feature macro: BICUBIC_FEEDER_EDGE_REPLICATE_EN
//     defined   : a start-of-line column fills all four window columns, so the
//                 first window of a line needs 3 columns (left edge replicated)
//     undefined : a start-of-line column discards older columns, so the first
//                 window of a line needs 4 columns
// ---------------------------------------------------------------------------
module bicubic_window_feeder #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bicubic_window_feeder_if.slave   io_feed
);
    localparam int CW   = CHANNEL_WIDTH;
    localparam int COLW = 4 * CW;
    localparam int OUTW = 8 * CW;

`ifdef BICUBIC_FEEDER_EDGE_REPLICATE_EN
    localparam logic [2:0] SOL_CNT = 3'd2;
`else
    localparam logic [2:0] SOL_CNT = 3'd1;
`endif

    typedef enum logic [1:0] {FILL, REQ_A, REQ_B} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [COLW-1:0]   r_col [4];
    logic              r_col_ready;
    logic              r_req_valid;

    logic [OUTW-1:0]   r_fifo_data  [2];
    logic              r_fifo_phase [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_fifo_cnt;

    logic              w_rsp_ready;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_col_acc;
    logic [2:0]        w_cnt_inc;
    logic [2:0]        w_cnt_fill;
    logic [OUTW-1:0]   w_rsp_word;

    assign w_rsp_ready = (r_fifo_cnt != 2'd2);
    assign w_hs        = io_feed.bcci_rsp_valid & w_rsp_ready;
    // Only the two expected phases of an active request reach the FIFO.
    assign w_push      = w_hs & (((r_state == REQ_A) & io_feed.bcci_req_ready) |
                                 (r_state == REQ_B));
    assign w_pop       = (r_fifo_cnt != 2'd0) & io_feed.out_ready;
    assign w_col_acc   = io_feed.col_valid & r_col_ready;
    assign w_cnt_inc   = (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
    assign w_rsp_word  = {io_feed.bcci_rsp_data8, io_feed.bcci_rsp_data7,
                          io_feed.bcci_rsp_data6, io_feed.bcci_rsp_data5,
                          io_feed.bcci_rsp_data4, io_feed.bcci_rsp_data3,
                          io_feed.bcci_rsp_data2, io_feed.bcci_rsp_data1};

    always_comb begin
        w_cnt_fill = w_cnt_inc;
        if (io_feed.col_sol) w_cnt_fill = SOL_CNT;
    end

    // Window FSM; col_ready / bf_req_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_cnt       <= 3'd0;
            r_col_ready <= 1'b1;
            r_req_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) r_col[i] <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_col_acc) begin
`ifdef BICUBIC_FEEDER_EDGE_REPLICATE_EN
                        if (io_feed.col_sol) begin
                            for (int unsigned i = 0; i < 4; i++) r_col[i] <= io_feed.col_data;
                        end else begin
                            r_col[0] <= r_col[1];
                            r_col[1] <= r_col[2];
                            r_col[2] <= r_col[3];
                            r_col[3] <= io_feed.col_data;
                        end
`else
                        r_col[0] <= r_col[1];
                        r_col[1] <= r_col[2];
                        r_col[2] <= r_col[3];
                        r_col[3] <= io_feed.col_data;
`endif
                        r_cnt <= w_cnt_fill;
                        if (w_cnt_fill == 3'd4) begin
                            r_state     <= REQ_A;
                            r_col_ready <= 1'b0;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                REQ_A: begin
                    if (w_hs && io_feed.bcci_req_ready) r_state <= REQ_B;
                end
                REQ_B: begin
                    // Keep three newest columns; one more column forms the next window.
                    if (w_hs) begin
                        r_state     <= FILL;
                        r_cnt       <= 3'd3;
                        r_col_ready <= 1'b1;
                        r_req_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_col_ready <= 1'b1;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // 2-entry response FIFO, no bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_phase[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= w_rsp_word;
                r_fifo_phase[r_wr_ptr] <= (r_state == REQ_B);
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign io_feed.col_ready    = r_col_ready;
    assign io_feed.bf_req_valid = r_req_valid;
    assign io_feed.bf_rsp_ready = w_rsp_ready;
    assign io_feed.out_valid    = (r_fifo_cnt != 2'd0);
    assign io_feed.out_data     = r_fifo_data[r_rd_ptr];
    assign io_feed.out_phase    = r_fifo_phase[r_rd_ptr];

    // p(4c+r+1) = window column c, row r
    assign io_feed.p1  = r_col[0][0*CW +: CW];
    assign io_feed.p2  = r_col[0][1*CW +: CW];
    assign io_feed.p3  = r_col[0][2*CW +: CW];
    assign io_feed.p4  = r_col[0][3*CW +: CW];
    assign io_feed.p5  = r_col[1][0*CW +: CW];
    assign io_feed.p6  = r_col[1][1*CW +: CW];
    assign io_feed.p7  = r_col[1][2*CW +: CW];
    assign io_feed.p8  = r_col[1][3*CW +: CW];
    assign io_feed.p9  = r_col[2][0*CW +: CW];
    assign io_feed.p10 = r_col[2][1*CW +: CW];
    assign io_feed.p11 = r_col[2][2*CW +: CW];
    assign io_feed.p12 = r_col[2][3*CW +: CW];
    assign io_feed.p13 = r_col[3][0*CW +: CW];
    assign io_feed.p14 = r_col[3][1*CW +: CW];
    assign io_feed.p15 = r_col[3][2*CW +: CW];
    assign io_feed.p16 = r_col[3][3*CW +: CW];
endmodule

// File: tb/tb_bicubic_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_bicubic_window_feeder
//   Self-checking bench for bicubic_window_feeder: a per-cycle vector table
//   for fill and the two-phase request, hand-written sequences for steady
//   state, backpressure, mid-request reset and start-of-line handling, then
//   randomized traffic against a queue-based reference model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bicubic_window_feeder;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bicubic_window_feeder_if #(.CHANNEL_WIDTH(CW)) bus ();
    bicubic_window_feeder #(.CHANNEL_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .io_feed(bus));

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] CA = 32'h10101010, CB = 32'h20202020, CC = 32'h30303030;
    localparam logic [31:0] CD = 32'h40404040, CE = 32'h50505050, CF = 32'h60606060;
    localparam logic [63:0] R0 = 64'hDEAD_BEEF_0000_0000, R1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] R2 = 64'h5555_6666_7777_8888;
`ifdef BICUBIC_FEEDER_EDGE_REPLICATE_EN
    localparam bit SOL_A = 1'b0;   // from reset the first window needs 4 columns in both builds
`else
    localparam bit SOL_A = 1'b1;
`endif

    typedef struct {
        bit cv; bit sol; logic [31:0] cd; bit rq; bit rv; logic [63:0] rd; bit ordy;
        bit e_cr; bit e_req; bit e_rr; bit e_ov; bit e_ph; logic [63:0] e_od; bit cwin;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] win();
        return {bus.p16, bus.p15, bus.p14, bus.p13, bus.p12, bus.p11, bus.p10, bus.p9,
                bus.p8, bus.p7, bus.p6, bus.p5, bus.p4, bus.p3, bus.p2, bus.p1};
    endfunction

    task automatic set_rsp(input logic [63:0] d);
        bus.bcci_rsp_data1 = d[7:0];   bus.bcci_rsp_data2 = d[15:8];
        bus.bcci_rsp_data3 = d[23:16]; bus.bcci_rsp_data4 = d[31:24];
        bus.bcci_rsp_data5 = d[39:32]; bus.bcci_rsp_data6 = d[47:40];
        bus.bcci_rsp_data7 = d[55:48]; bus.bcci_rsp_data8 = d[63:56];
    endtask

    task automatic drive(input bit cv, input bit sol, input logic [31:0] cd, input bit rq,
                         input bit rv, input logic [63:0] rd, input bit ordy);
        bus.col_valid = cv; bus.col_sol = sol; bus.col_data = cd;
        bus.bcci_req_ready = rq; bus.bcci_rsp_valid = rv; set_rsp(rd);
        bus.out_ready = ordy;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, ordy);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit cv, bit sol, logic [31:0] cd, bit rq, bit rv, logic [63:0] rd,
                                bit ordy, bit cr, bit req, bit rr, bit ov, bit ph,
                                logic [63:0] od, bit cwin);
        vec_t v;
        v.cv = cv; v.sol = sol; v.cd = cd; v.rq = rq; v.rv = rv; v.rd = rd; v.ordy = ordy;
        v.e_cr = cr; v.e_req = req; v.e_rr = rr; v.e_ov = ov; v.e_ph = ph; v.e_od = od;
        v.cwin = cwin;
        return v;
    endfunction

    task automatic do_reset();
        idle(1'b1);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    // Completes the current request with two accepted responses and drains.
    task automatic finish_window();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, R1, 1'b1); step();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, R2, 1'b1); step();
        idle(1'b1); step(); step();
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] m_cols [$];
    logic [64:0] m_q [$];      // {data, phase}
    int          m_phase;

    vec_t tbl [9];
    logic [127:0] w0;

    initial begin
        do_reset();
        // reset state (sampled while still at the release edge)
        chk("rst_col_ready", bus.col_ready, 1'b1);
        chk("rst_req_valid", bus.bf_req_valid, 1'b0);
        chk("rst_rsp_ready", bus.bf_rsp_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_phase", bus.out_phase, 1'b0);
        chk("rst_out_data",  bus.out_data, 64'h0);

        // ---------------- vector table: fill + two-phase request ----------------
        w0 = {CD, CC, CB, CA};
        tbl[0] = mk(1, SOL_A, CA, 0, 0, '0, 1,  1, 0, 1, 0, 0, '0, 0);
        tbl[1] = mk(1, 0,     CB, 0, 0, '0, 1,  1, 0, 1, 0, 0, '0, 0);
        tbl[2] = mk(1, 0,     CC, 0, 0, '0, 1,  1, 0, 1, 0, 0, '0, 0);
        tbl[3] = mk(1, 0,     CD, 0, 0, '0, 1,  0, 1, 1, 0, 0, '0, 1);
        tbl[4] = mk(1, 0,     CE, 0, 1, R0, 1,  0, 1, 1, 0, 0, '0, 1);   // hs w/o req_ready: ignored
        tbl[5] = mk(0, 0,     '0, 1, 1, R1, 0,  0, 1, 1, 1, 0, R1, 1);   // phase A
        tbl[6] = mk(0, 0,     '0, 0, 1, R2, 0,  1, 0, 0, 1, 0, R1, 0);   // phase B, FIFO full
        tbl[7] = mk(0, 0,     '0, 0, 0, '0, 1,  1, 0, 1, 1, 1, R2, 0);
        tbl[8] = mk(0, 0,     '0, 0, 0, '0, 1,  1, 0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].cv, tbl[i].sol, tbl[i].cd, tbl[i].rq, tbl[i].rv, tbl[i].rd, tbl[i].ordy);
            step();
            chk($sformatf("tbl%0d_col_ready", i), bus.col_ready, tbl[i].e_cr);
            chk($sformatf("tbl%0d_req_valid", i), bus.bf_req_valid, tbl[i].e_req);
            chk($sformatf("tbl%0d_rsp_ready", i), bus.bf_rsp_ready, tbl[i].e_rr);
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_phase", i), bus.out_phase, tbl[i].e_ph);
                chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].e_od);
            end
            if (tbl[i].cwin) chk($sformatf("tbl%0d_window", i), win(), w0);
        end

        // ---------------- steady state + backpressure ----------------
        drive(1, 0, CE, 0, 0, '0, 0); step();
        chk("ss_req_valid", bus.bf_req_valid, 1'b1);
        chk("ss_window_shift", win(), {CE, CD, CC, CB});
        drive(0, 0, '0, 1, 1, 64'hA1, 0); step();
        chk("bp_out_phase0", bus.out_phase, 1'b0);
        drive(0, 0, '0, 0, 1, 64'hA2, 0); step();
        chk("bp_full_rsp_ready", bus.bf_rsp_ready, 1'b0);
        chk("bp_req_dropped", bus.bf_req_valid, 1'b0);
        drive(1, 0, CF, 0, 0, '0, 0); step();
        chk("bp_win2_req", bus.bf_req_valid, 1'b1);
        chk("bp_win2_window", win(), {CF, CE, CD, CC});
        drive(0, 0, '0, 1, 1, 64'hA3, 0); step(); step();
        chk("bp_stall_req_valid", bus.bf_req_valid, 1'b1);
        chk("bp_stall_col_ready", bus.col_ready, 1'b0);
        chk("bp_stall_head", bus.out_data, 64'hA1);
        drive(0, 0, '0, 0, 0, '0, 1); step();
        chk("bp_drain1_data", bus.out_data, 64'hA2);
        chk("bp_drain1_phase", bus.out_phase, 1'b1);
        step();
        chk("bp_drain2_empty", bus.out_valid, 1'b0);
        chk("bp_still_req_a", bus.bf_req_valid, 1'b1);
        drive(0, 0, '0, 1, 1, 64'hA3, 1); step();
        chk("pp_phase0_data", bus.out_data, 64'hA3);
        drive(0, 0, '0, 0, 1, 64'hA4, 1); step();   // push and pop in the same cycle
        chk("pp_valid", bus.out_valid, 1'b1);
        chk("pp_data", bus.out_data, 64'hA4);
        chk("pp_phase", bus.out_phase, 1'b1);
        idle(1); step();
        chk("pp_empty", bus.out_valid, 1'b0);

        // ---------------- reset mid-REQ_B ----------------
        drive(1, 0, 32'h70707070, 0, 0, '0, 0); step();
        drive(0, 0, '0, 1, 1, 64'hB1, 0); step();
        chk("mr_in_req_b", bus.bf_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_valid", bus.bf_req_valid, 1'b0);
        chk("mr_out_valid", bus.out_valid, 1'b0);
        chk("mr_col_ready", bus.col_ready, 1'b1);
        idle(1); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, {4{8'(8'h81 + i)}}, 0, 0, '0, 1); step();
            chk($sformatf("mr_fill%0d_no_req", i), bus.bf_req_valid, 1'b0);
        end
        drive(1, 0, {4{8'h84}}, 0, 0, '0, 1); step();
        chk("mr_fill3_req", bus.bf_req_valid, 1'b1);
        chk("mr_window", win(), {{4{8'h84}}, {4{8'h83}}, {4{8'h82}}, {4{8'h81}}});
        finish_window();

        // ---------------- start-of-line handling ----------------
        drive(1, 1, {4{8'hC0}}, 0, 0, '0, 1); step();
        chk("sol_s_no_req", bus.bf_req_valid, 1'b0);
        drive(1, 0, {4{8'hC1}}, 0, 0, '0, 1); step();
        chk("sol_x1_no_req", bus.bf_req_valid, 1'b0);
        drive(1, 0, {4{8'hC2}}, 0, 0, '0, 1); step();
`ifdef BICUBIC_FEEDER_EDGE_REPLICATE_EN
        chk("sol_x2_req", bus.bf_req_valid, 1'b1);
        chk("sol_edge_window", win(), {{4{8'hC2}}, {4{8'hC1}}, {4{8'hC0}}, {4{8'hC0}}});
`else
        chk("sol_x2_no_req", bus.bf_req_valid, 1'b0);
        drive(1, 0, {4{8'hC3}}, 0, 0, '0, 1); step();
        chk("sol_x3_req", bus.bf_req_valid, 1'b1);
        chk("sol_window", win(), {{4{8'hC3}}, {4{8'hC2}}, {4{8'hC1}}, {4{8'hC0}}});
`endif
        finish_window();

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        m_cols = {};
        m_q = {};
        m_phase = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit req, full, cv, sol, rq, rv, ordy, hs;
            logic [31:0] cd;
            logic [63:0] rd;
            req  = (m_cols.size() == 4);
            full = (m_q.size() == 2);
            chk("rnd_col_ready", bus.col_ready, !req);
            chk("rnd_req_valid", bus.bf_req_valid, req);
            chk("rnd_rsp_ready", bus.bf_rsp_ready, !full);
            chk("rnd_out_valid", bus.out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rnd_out_data", bus.out_data, m_q[0][64:1]);
                chk("rnd_out_phase", bus.out_phase, m_q[0][0]);
            end
            if (req) chk("rnd_window", win(), {m_cols[3], m_cols[2], m_cols[1], m_cols[0]});

            cv   = ($urandom_range(3) != 0);
            sol  = ($urandom_range(9) == 0);
            cd   = $urandom;
            rq   = $urandom_range(1);
            rv   = $urandom_range(1);
            rd   = {$urandom, $urandom};
            ordy = ($urandom_range(3) != 0);
            drive(cv, sol, cd, rq, rv, rd, ordy);

            hs = rv && !full;
            if (ordy && m_q.size() != 0) void'(m_q.pop_front());
            if (req && hs) begin
                if (m_phase == 0 && rq) begin
                    m_q.push_back({rd, 1'b0});
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_q.push_back({rd, 1'b1});
                    m_phase = 0;
                    void'(m_cols.pop_front());
                end
            end else if (!req && cv) begin
                if (sol) begin
`ifdef BICUBIC_FEEDER_EDGE_REPLICATE_EN
                    m_cols = {cd, cd};
`else
                    m_cols = {cd};
`endif
                end else begin
                    m_cols.push_back(cd);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bicubic_window_feeder.md
BICUBIC_WINDOW_FEEDER -- requirements
Module: bicubic_window_feeder

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8, giving bits per pixel.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port col_valid, input, 1, an upstream column is offered.
REQ-005 SHALL have port col_ready, output, 1, the feeder accepts the column.
REQ-006 SHALL have port col_data, input, 4*CHANNEL_WIDTH, pixel rows 0..3, with row r in bits [r*CW+:CW].
REQ-007 SHALL have port col_sol, input, 1, the column is the first of a line.
REQ-008 SHALL have port bf_req_valid, output, 1, the window request to the upsampler.
REQ-009 SHALL have port bcci_req_ready, input, 1, the upsampler is in its first phase.
REQ-010 SHALL have ports p1..p16, output, CHANNEL_WIDTH each, with p(4c+r+1) = window column c (0 oldest), row r.
REQ-011 SHALL have port bcci_rsp_valid, input, 1, upsampler response valid.
REQ-012 SHALL have port bf_rsp_ready, output, 1, the feeder accepts the response.
REQ-013 SHALL have ports bcci_rsp_data1..8, input, CHANNEL_WIDTH each, upsampled pixels.
REQ-014 SHALL have ports out_valid/out_ready, output/input, 1 each, downstream handshake.
REQ-015 SHALL have port out_data, output, 8*CHANNEL_WIDTH, {data8..data1}, with data1 in the LSBs.
REQ-016 SHALL have port out_phase, output, 1: 0 for the first response of a window, 1 for the second.

Function
REQ-017 SHALL implement an FSM with states FILL, REQ_A and REQ_B, plus a fill counter cnt (0..4) and four window column registers.
REQ-018 SHALL drive col_ready=1 only in FILL; on an accepted column: col0<-col1<-col2<-col3<-col_data, cnt<-cnt+1 (saturating at 4).
REQ-019 SHALL, for an accepted column with col_sol=1, set cnt to 1 after the shift, discarding earlier columns.
REQ-020 SHALL move FILL->REQ_A in the same cycle that cnt reaches 4, so bf_req_valid rises on the next cycle.
REQ-021 SHALL drive bf_req_valid=1 in REQ_A and REQ_B, holding p1..p16 stable for the whole request.
REQ-022 SHALL drive bf_rsp_ready=1 when the output FIFO is not full; response handshake hs = bcci_rsp_valid & bf_rsp_ready.
REQ-023 SHALL move REQ_A->REQ_B on hs & bcci_req_ready; hs without bcci_req_ready SHALL be ignored and SHALL NOT push.
REQ-024 SHALL move REQ_B->FILL on hs and set cnt=3, so exactly one new column forms the next window.
REQ-025 SHALL push {data8..1, phase} into a 2-entry FIFO on each accepted hs, with phase=0 in REQ_A and 1 in REQ_B.
REQ-026 SHALL drive out_valid when the FIFO is non-empty, present the head entry, and pop on out_valid & out_ready.
REQ-027 SHALL allow a simultaneous push and pop when the FIFO holds one entry; there is no bypass, so minimum response-to-out_valid latency is 1 cycle.
REQ-028 SHALL, when the FIFO is full, hold bf_rsp_ready=0 and the FSM SHALL stall in its current state.

Reset
REQ-029 SHALL, on rst_n low, immediately set: state FILL, cnt 0, window columns 0, FIFO empty, out_valid 0, bf_req_valid 0, out_phase 0, out_data 0.
REQ-030 SHALL discard any in-flight window or buffered response on reset assertion mid-operation.

Configuration
REQ-031 SHALL support macro BICUBIC_FEEDER_EDGE_REPLICATE_EN.
REQ-032 SHALL, when that macro is defined, load an accepted col_sol column into all four columns and set cnt=2, so the first window of a line needs 3 columns and replicates the left edge.
REQ-033 SHALL, when that macro is undefined, behave per REQ-019, so the first window of a line needs 4 columns.

Verification
REQ-034 SHALL cover fill: columns A,B,C,D (each row = 0x10,0x20,0x30,0x40), A with sol -> bf_req_valid rises one cycle after D accepted; p1..p4=A and p13..p16=D.
REQ-035 SHALL cover the two-phase request: bcci_req_ready=1, hs in cycle n; bcci_req_ready=0, hs in cycle n+1 -> two FIFO entries with out_phase 0 then 1; bf_req_valid falls at n+2.
REQ-036 SHALL cover backpressure: out_ready=0 for 2 windows -> after 2 pushes bf_rsp_ready=0 and state is held; releasing out_ready drains the entries in order.
REQ-037 SHALL cover steady state: after the first window, one column plus two hs per window -> the next window shifts by exactly one column (p1..p4 = B).
REQ-038 SHALL cover reset mid-REQ_B: rst_n low -> bf_req_valid=0, out_valid=0 immediately; 4 new columns are needed for the next request.
REQ-039 SHALL cover BICUBIC_FEEDER_EDGE_REPLICATE_EN: sol column S then X1, X2 -> first window = {S,S,X1,X2} after 3 columns.
